counter_sched: RTL and testbench

COUNTER_SCHED -- requirements
Module: counter_sched

---
 rtl/counter_sched.sv | 117 +++++++++++
 tb/tb_counter_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// Round-robin scheduler granting a shared down-counter to one of NREQ requesters.
// Optional abort input is enabled by defining COUNTER_SCHED_ABORT_EN.
module counter_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] load_val,
`ifdef COUNTER_SCHED_ABORT_EN
    input  logic                  abort,
`endif
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      value
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   w_grant_nxt;
    logic [WIDTH-1:0]  r_value;
    logic [WIDTH-1:0]  w_value_nxt;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     w_ptr_nxt;

    logic              w_found;
    logic [PW-1:0]     w_win;
    logic [WIDTH-1:0]  w_slice;

    // Search starts one past the last winner, so the previous owner ranks last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!w_found && req[(32'(r_ptr) + i) % NREQ]) begin
                w_found = 1'b1;
                w_win   = PW'((32'(r_ptr) + i) % NREQ);
            end
        end
    end

    assign w_slice = load_val[32'(w_win) * WIDTH +: WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_value_nxt = r_value;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = NREQ'(1) << w_win;
                    w_value_nxt = w_slice;
                    w_ptr_nxt   = w_win;
                    w_state_nxt = (w_slice != '0) ? COUNT : DONE;
                end
            end
            COUNT: begin
`ifdef COUNTER_SCHED_ABORT_EN
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_value_nxt = '0;
                end else
`endif
                begin
                    if (r_value != '0) begin
                        w_value_nxt = r_value - WIDTH'(1);
                    end
                    if (r_value <= WIDTH'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_value_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_value <= '0;
            r_ptr   <= PW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_value <= w_value_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign grant = r_grant;
    assign value = r_value;
    assign busy  = (r_state != IDLE);
    assign done  = (r_state == DONE) ? r_grant : '0;

endmodule

// File: tb/tb_counter_sched.sv
// Randomized self-checking bench for counter_sched; the reference model expands each
// grant into its full expected output schedule. Honours COUNTER_SCHED_ABORT_EN.
module tb_counter_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] load_val;
    logic                  abort;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      value;

    counter_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .load_val (load_val),
`ifdef COUNTER_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .grant    (grant),
        .busy     (busy),
        .done     (done),
        .value    (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  g;
        logic             b;
        logic [NREQ-1:0]  d;
        logic [WIDTH-1:0] v;
    } exp_t;

    localparam exp_t IDLE_E = '{g: '0, b: 1'b0, d: '0, v: '0};

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_ptr;
    exp_t cur;
    exp_t pend[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp_v);
        end
    endtask

    // A grant of load L yields L+1 owned cycles counting L..0 (done on 0), then one idle cycle.
    task automatic model_edge();
        int   w;
        int   ld;
        exp_t e;
        if (!reset) begin
            pend.delete();
            cur   = IDLE_E;
            m_ptr = NREQ - 1;
            return;
        end
`ifdef COUNTER_SCHED_ABORT_EN
        if (abort && cur.b && cur.d == '0) begin
            pend.delete();
            cur = IDLE_E;
            return;
        end
`endif
        if (pend.size() > 0) begin
            cur = pend.pop_front();
            return;
        end
        if (req == '0) return;
        w = -1;
        for (int i = 1; i <= NREQ; i++) begin
            if (w < 0 && req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
        end
        m_ptr = w;
        ld    = int'(load_val[w*WIDTH +: WIDTH]);
        for (int k = ld; k >= 0; k--) begin
            e.g = NREQ'(1) << w;
            e.b = 1'b1;
            e.v = WIDTH'(k);
            e.d = (k == 0) ? e.g : '0;
            pend.push_back(e);
        end
        pend.push_back(IDLE_E);
        cur = pend.pop_front();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("grant", 32'(grant), 32'(cur.g));
        check("busy",  32'(busy),  32'(cur.b));
        check("done",  32'(done),  32'(cur.d));
        check("value", 32'(value), 32'(cur.v));
    endtask

    task automatic run_until_value(input logic [WIDTH-1:0] target);
        int n;
        n = 0;
        while (cur.v != target && n < 40) begin
            step();
            n++;
        end
        if (cur.v != target) check("wait_timeout", 32'(n), 32'(0));
    endtask

    initial begin
        cur      = IDLE_E;
        m_ptr    = NREQ - 1;
        reset    = 1'b0;
        req      = '1;
        load_val = '0;
        abort    = 1'b0;

        // Reset held with all requests pending
        repeat (2) step();
        check("rst_grant", 32'(grant), 32'(0));

        // Single request, load 3
        reset    = 1'b1;
        req      = 4'b0001;
        load_val = {8'd0, 8'd0, 8'd0, 8'd3};
        step();
        check("single_first_grant", 32'(grant), 32'h1);
        check("single_first_value", 32'(value), 32'h3);
        req = '0;
        repeat (6) step();

        // Zero load on requester 2
        req      = 4'b0100;
        load_val = '0;
        step();
        check("zero_grant", 32'(grant), 32'h4);
        check("zero_done",  32'(done),  32'h4);
        req = '0;
        repeat (3) step();

        // Fairness with all loads 1
        reset = 1'b0;
        step();
        reset    = 1'b1;
        req      = 4'b1111;
        load_val = {8'd1, 8'd1, 8'd1, 8'd1};
        repeat (16) step();
        req = '0;
        repeat (3) step();

        // Reset in mid-count, then round-robin restarts at requester 0's successor order
        req      = 4'b0001;
        load_val = {8'd0, 8'd0, 8'd0, 8'd9};
        step();
        req = '0;
        run_until_value(8'd5);
        reset = 1'b0;
        step();
        check("midrst_done", 32'(done), 32'(0));
        reset    = 1'b1;
        req      = 4'b1010;
        load_val = {8'd2, 8'd0, 8'd2, 8'd0};
        step();
        check("midrst_rr_grant", 32'(grant), 32'h2);
        req = '0;
        repeat (6) step();

`ifdef COUNTER_SCHED_ABORT_EN
        req      = 4'b0001;
        load_val = {8'd0, 8'd0, 8'd0, 8'd10};
        step();
        req = '0;
        run_until_value(8'd6);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_grant", 32'(grant), 32'(0));
        check("abort_value", 32'(value), 32'(0));
        repeat (4) step();
`endif

        // Random traffic with occasional reset and abort
        for (int c = 0; c < 3000; c++) begin
            req = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                load_val[i*WIDTH +: WIDTH] = ($urandom_range(0, 15) == 0) ?
                    WIDTH'($urandom_range(0, 255)) : WIDTH'($urandom_range(0, 6));
            end
            reset = ($urandom_range(0, 63) != 0);
            abort = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
